// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: collects operand A, operand B and opcode bytes from the
// UART receiver, validates the opcode, drives the ALU, and hands the result
// byte to the UART transmitter.
// Latency: opcode accept at edge k -> o_tx_start/o_tx_data after edge k+2.
// Backpressure: none towards the receiver. Bytes that arrive while busy
// (EXEC/SEND/WAIT_TX) are dropped and flagged on o_overrun.
//
// Ports:
//   i_clock, i_reset         clock; synchronous active-high reset
//   i_rx_done_tick/i_rx_data received-byte strobe and byte
//   i_tx_done_tick           transmitter finished the current byte
//   i_alu_result             combinational result from the ALU
//   o_alu_a/o_alu_b/o_alu_op registered ALU operands and opcode
//   o_tx_start/o_tx_data     one-cycle start strobe and registered result byte
//   o_busy                   high from opcode accept until tx done
//   o_timeout/o_op_error/o_overrun  one-cycle status pulses
module uart_alu_sequencer #(
  parameter int NB_DATA   = 8,
  parameter int NB_OP     = 6,
  parameter int N_TIMEOUT = 1000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done_tick,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_op_error,
  output logic               o_overrun
);

  // Counter only has to reach N_TIMEOUT-1; it is cleared at terminal count,
  // so it can never wrap.
  localparam int CNT_W = (N_TIMEOUT > 1) ? $clog2(N_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [NB_DATA-1:0] alu_a_q;
  logic [NB_DATA-1:0] alu_b_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               timeout_q;
  logic               op_error_q;
  logic               overrun_q;

  logic               op_valid;
  logic               cnt_last;

  // Opcode byte is legal only when the bits above the opcode field are zero
  // and the field holds one of the supported ALU functions.
  always_comb begin
    op_valid = 1'b0;
    if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
      case (i_rx_data[NB_OP-1:0])
        NB_OP'(6'b100000),  // ADD
        NB_OP'(6'b100010),  // SUB
        NB_OP'(6'b100100),  // AND
        NB_OP'(6'b100101),  // OR
        NB_OP'(6'b100110),  // XOR
        NB_OP'(6'b100111),  // NOR
        NB_OP'(6'b000011),  // SRA
        NB_OP'(6'b000010):  // SRL
          op_valid = 1'b1;
        default:
          op_valid = 1'b0;
      endcase
    end
  end

  assign cnt_last = (cnt_q == CNT_LAST);
  assign cnt_d    = cnt_q + CNT_ONE;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      op_error_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-armed below.
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      op_error_q <= 1'b0;
      // busy_q is high exactly in EXEC/SEND/WAIT_TX, where bytes are dropped.
      overrun_q  <= i_rx_done_tick & busy_q;

      case (state_q)
        WAIT_A: begin
          if (i_rx_done_tick) begin
            alu_a_q <= i_rx_data;
            cnt_q   <= '0;
            state_q <= WAIT_B;
          end
        end

        WAIT_B: begin
          // An arriving byte takes priority over the terminal count.
          if (i_rx_done_tick) begin
            alu_b_q <= i_rx_data;
            cnt_q   <= '0;
            state_q <= WAIT_OP;
          end else if (cnt_last) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= WAIT_A;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        WAIT_OP: begin
          if (i_rx_done_tick) begin
            cnt_q <= '0;
            if (op_valid) begin
              alu_op_q <= i_rx_data[NB_OP-1:0];
              busy_q   <= 1'b1;
              state_q  <= EXEC;
            end else begin
              op_error_q <= 1'b1;
              state_q    <= WAIT_A;
            end
          end else if (cnt_last) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= WAIT_A;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        // One cycle for the ALU output to settle on the new operands.
        EXEC: begin
          state_q <= SEND;
        end

        SEND: begin
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_TX;
        end

        WAIT_TX: begin
          if (i_tx_done_tick) begin
            busy_q  <= 1'b0;
            state_q <= WAIT_A;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= WAIT_A;
        end
      endcase
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;
  assign o_op_error = op_error_q;
  assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Bench for uart_alu_sequencer: table of three-byte transactions with
// hand-computed results, plus directed sequences for timeout, overrun,
// reset mid-transaction and ignored tx-done.
module tb_uart_alu_sequencer;

  logic       clk;
  logic       i_reset;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_done;
  logic [7:0] alu_res;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       timeout;
  logic       op_error;
  logic       overrun;

  int n_pass  = 0;
  int n_total = 0;
  logic [5:0] exp_op;

  uart_alu_sequencer #(.NB_DATA(8), .NB_OP(6), .N_TIMEOUT(16)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_rx_done_tick(rx_done),
    .i_rx_data     (rx_data),
    .i_tx_done_tick(tx_done),
    .i_alu_result  (alu_res),
    .o_alu_a       (alu_a),
    .o_alu_b       (alu_b),
    .o_alu_op      (alu_op),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .o_busy        (busy),
    .o_timeout     (timeout),
    .o_op_error    (op_error),
    .o_overrun     (overrun)
  );

  // Behavioural stand-in for the ALU the sequencer drives.
  always_comb begin
    case (alu_op)
      6'h20:   alu_res = alu_a + alu_b;
      6'h22:   alu_res = alu_a - alu_b;
      6'h24:   alu_res = alu_a & alu_b;
      6'h25:   alu_res = alu_a | alu_b;
      6'h26:   alu_res = alu_a ^ alu_b;
      6'h27:   alu_res = ~(alu_a | alu_b);
      6'h03:   alu_res = $signed(alu_a) >>> alu_b;
      6'h02:   alu_res = alu_a >> alu_b;
      default: alu_res = 8'h00;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Called at a negedge; byte is taken on the next rising edge and the task
  // returns at the negedge right after it.
  task automatic send(logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic check_reset(string nm);
    chk($sformatf("%s alu_a", nm),    32'(alu_a),    32'h0);
    chk($sformatf("%s alu_b", nm),    32'(alu_b),    32'h0);
    chk($sformatf("%s alu_op", nm),   32'(alu_op),   32'h0);
    chk($sformatf("%s tx_data", nm),  32'(tx_data),  32'h0);
    chk($sformatf("%s pulses", nm),
        32'({tx_start, busy, timeout, op_error, overrun}), 32'h0);
    exp_op = 6'h0;
  endtask

  task automatic finish_op(string nm, logic [7:0] op, logic ok, logic [7:0] res);
    logic seen;
    send(op);
    if (ok) begin
      exp_op = op[5:0];
      chk($sformatf("%s busy_on", nm), 32'(busy), 32'h1);
      chk($sformatf("%s alu_op", nm), 32'(alu_op), 32'(exp_op));
      @(negedge clk);
      chk($sformatf("%s exec_no_start", nm), 32'(tx_start), 32'h0);
      @(negedge clk);
      chk($sformatf("%s tx_start", nm), 32'(tx_start), 32'h1);
      chk($sformatf("%s tx_data", nm), 32'(tx_data), 32'(res));
      @(negedge clk);
      chk($sformatf("%s start_once", nm), 32'(tx_start), 32'h0);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk($sformatf("%s busy_off", nm), 32'(busy), 32'h0);
    end else begin
      chk($sformatf("%s op_error", nm), 32'(op_error), 32'h1);
      chk($sformatf("%s not_busy", nm), 32'(busy), 32'h0);
      chk($sformatf("%s op_kept", nm), 32'(alu_op), 32'(exp_op));
      seen = 1'b0;
      repeat (3) begin
        @(negedge clk);
        seen = seen | tx_start | op_error;
      end
      chk($sformatf("%s no_start_no_repeat", nm), 32'(seen), 32'h0);
    end
  endtask

  task automatic run_txn(string nm, logic [7:0] a, logic [7:0] b,
                         logic [7:0] op, logic ok, logic [7:0] res);
    send(a);
    chk($sformatf("%s A", nm), 32'(alu_a), 32'(a));
    send(b);
    chk($sformatf("%s B", nm), 32'(alu_b), 32'(b));
    finish_op(nm, op, ok, res);
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic       ok;
    logic [7:0] res;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic seen;

    vecs[0]  = '{a: 8'h05, b: 8'h03, op: 8'h20, ok: 1'b1, res: 8'h08}; // ADD
    vecs[1]  = '{a: 8'h0A, b: 8'h0F, op: 8'h3F, ok: 1'b0, res: 8'h00}; // bad op
    vecs[2]  = '{a: 8'h01, b: 8'h01, op: 8'h22, ok: 1'b1, res: 8'h00}; // SUB
    vecs[3]  = '{a: 8'hF0, b: 8'h3C, op: 8'h24, ok: 1'b1, res: 8'h30}; // AND
    vecs[4]  = '{a: 8'hF0, b: 8'h0F, op: 8'h25, ok: 1'b1, res: 8'hFF}; // OR
    vecs[5]  = '{a: 8'hAA, b: 8'hFF, op: 8'h26, ok: 1'b1, res: 8'h55}; // XOR
    vecs[6]  = '{a: 8'h0F, b: 8'h30, op: 8'h27, ok: 1'b1, res: 8'hC0}; // NOR
    vecs[7]  = '{a: 8'h80, b: 8'h03, op: 8'h03, ok: 1'b1, res: 8'hF0}; // SRA
    vecs[8]  = '{a: 8'h80, b: 8'h03, op: 8'h02, ok: 1'b1, res: 8'h10}; // SRL
    vecs[9]  = '{a: 8'h05, b: 8'h03, op: 8'h60, ok: 1'b0, res: 8'h00}; // bit6 set
    vecs[10] = '{a: 8'h05, b: 8'h03, op: 8'hA0, ok: 1'b0, res: 8'h00}; // bit7 set
    vecs[11] = '{a: 8'hFF, b: 8'h01, op: 8'h20, ok: 1'b1, res: 8'h00}; // ADD wrap

    i_reset = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    tx_done = 1'b0;
    exp_op  = 6'h0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    check_reset("por");

    // Table: each transaction starts on the edge right after the previous
    // tx-done, so these are back-to-back.
    for (int i = 0; i < 12; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
              vecs[i].ok, vecs[i].res);

    // Timeout after operand A: pulse lands 16 edges after the byte.
    send(8'h11);
    chk("to A", 32'(alu_a), 32'h11);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | timeout;
    end
    chk("to early", 32'(seen), 32'h0);
    @(negedge clk);
    chk("to pulse", 32'(timeout), 32'h1);
    @(negedge clk);
    chk("to pulse_once", 32'(timeout), 32'h0);

    // Byte arriving on the terminal-count edge is accepted as B.
    send(8'h22);
    chk("term A", 32'(alu_a), 32'h22);
    repeat (15) @(negedge clk);
    send(8'h33);
    chk("term B", 32'(alu_b), 32'h33);
    chk("term no_to", 32'(timeout), 32'h0);
    finish_op("term", 8'h20, 1'b1, 8'h55);

    // Byte during WAIT_TX is dropped and flagged.
    send(8'h04);
    send(8'h02);
    send(8'h20);
    @(negedge clk);
    @(negedge clk);
    chk("ovr tx_data", 32'(tx_data), 32'h06);
    @(negedge clk);
    send(8'h77);
    chk("ovr pulse", 32'(overrun), 32'h1);
    chk("ovr data_kept", 32'(tx_data), 32'h06);
    chk("ovr a_kept", 32'(alu_a), 32'h04);
    chk("ovr busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("ovr pulse_once", 32'(overrun), 32'h0);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("ovr busy_off", 32'(busy), 32'h0);
    run_txn("fresh", 8'h09, 8'h01, 8'h22, 1'b1, 8'h08);

    // Reset while waiting for the opcode.
    send(8'h12);
    send(8'h34);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_reset("rst_op");
    run_txn("after_rst_op", 8'h07, 8'h02, 8'h22, 1'b1, 8'h05);

    // Reset while waiting for the transmitter.
    send(8'h06);
    send(8'h07);
    send(8'h20);
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx start", 32'(tx_start), 32'h1);
    chk("rst_tx data", 32'(tx_data), 32'h0D);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check_reset("rst_tx");

    // tx-done outside WAIT_TX does nothing.
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("stray_done", 32'({busy, tx_start}), 32'h0);
    run_txn("b2b_srl", 8'h80, 8'h03, 8'h02, 1'b1, 8'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Controller sitting between the UART receiver/transmitter pair and the ALU. Collects three received bytes per transaction (operand A, operand B, opcode), validates the opcode, presents operands to the ALU, then hands the result byte to the UART transmitter and waits for its completion. Includes an inter-byte timeout so a lost byte never wedges the link.

## Interface
- NB_DATA, 8, operand/result/UART byte width
- NB_OP, 6, ALU opcode width (low bits of the opcode byte)
- N_TIMEOUT, 1000000, clock cycles allowed between bytes of one transaction
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  reset i_reset, synchronous, active-high
- i_rx_done_tick  in  1  one-cycle pulse, received byte valid on i_rx_data
- i_rx_data  in  NB_DATA  received byte
- i_tx_done_tick  in  1  one-cycle pulse, transmitter finished current byte
- i_alu_result  in  NB_DATA  combinational ALU result
- o_alu_a, o_alu_b  out  NB_DATA  registered operands to ALU
- o_alu_op  out  NB_OP  registered opcode to ALU
- o_tx_start  out  1  one-cycle pulse, start transmission of o_tx_data
- o_tx_data  out  NB_DATA  registered result byte
- o_busy  out  1  high from opcode accept until tx done
- o_timeout  out  1  one-cycle pulse, transaction aborted by timeout
- o_op_error  out  1  one-cycle pulse, invalid opcode rejected
- o_overrun  out  1  one-cycle pulse, byte received while busy and dropped

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done_tick latch i_rx_data into o_alu_a, go WAIT_B, clear timeout counter. No timeout in WAIT_A.
- WAIT_B: on i_rx_done_tick latch o_alu_b, go WAIT_OP, clear counter; else counter +1; counter reaching N_TIMEOUT-1 -> pulse o_timeout, go WAIT_A.
- WAIT_OP: on i_rx_done_tick check byte: valid iff bits [NB_DATA-1:NB_OP] all zero and low NB_OP bits in {100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL}. Valid -> latch o_alu_op, go EXEC. Invalid -> pulse o_op_error, o_alu_op unchanged, go WAIT_A. Timeout as in WAIT_B.
- EXEC: one settling cycle; go SEND.
- SEND: capture i_alu_result into o_tx_data, pulse o_tx_start, go WAIT_TX.
- WAIT_TX: on i_tx_done_tick go WAIT_A. No timeout.
- i_rx_done_tick in EXEC/SEND/WAIT_TX: byte dropped, o_overrun pulses next cycle, state unaffected.
- Byte and counter terminal count in same cycle: byte wins, no timeout.
- i_tx_done_tick outside WAIT_TX ignored.
- Timeout counter width ceil(log2(N_TIMEOUT)); saturation impossible since terminal count resets it.
- Reset mid-transaction: abort immediately, no tx pulse, all state returns to reset values.

## Timing
- Reset values: state WAIT_A, o_alu_a/b=0, o_alu_op=0, o_tx_data=0, counter=0, all pulse outputs 0, o_busy=0.
- All outputs registered. Byte pulse at edge k -> corresponding register valid after edge k.
- Opcode accepted at edge k: o_busy=1 after edge k; EXEC during cycle k..k+1; o_tx_start=1 for exactly one cycle after edge k+2, o_tx_data valid same cycle and held until next SEND.
- i_tx_done_tick at edge m in WAIT_TX -> WAIT_A and o_busy=0 after edge m; a byte at edge m+1 is accepted as operand A.
- o_timeout/o_op_error/o_overrun: exactly one cycle, asserted the cycle after the triggering edge.

## Test plan
- Reset, send 0x05, 0x03, 0x20 (ADD) -> o_alu_a=5, o_alu_b=3, o_tx_start single pulse 2 cycles after opcode, o_tx_data=0x08; after i_tx_done_tick o_busy=0.
- Send 0x0A, 0x0F, 0x3F (invalid) -> o_op_error one pulse, no o_tx_start, next 0x01,0x01,0x22 yields result 0x00 transmitted.
- N_TIMEOUT=16: send 0x11, then silence -> o_timeout pulse 16 cycles after byte, state WAIT_A; byte at exact terminal cycle instead -> accepted as B, no timeout.
- During WAIT_TX inject i_rx_done_tick with 0x77 -> o_overrun pulse, o_tx_data unchanged, next transaction uses fresh A.
- Assert i_reset in WAIT_OP and again in WAIT_TX -> all outputs at reset values next cycle, no o_tx_start.
- Back-to-back: i_tx_done_tick followed immediately by new three-byte transaction (SRL 0x80 by 0x03, opcode 0x02) -> o_tx_data=0x10.
